// File: rtl/reg_file_param_if.sv
// Bus between the decode/writeback stages (master) and the register file (slave).
// Carries the read ports, the writeback port, the issue port and the scoreboard view.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2
);
    // Read ports, packed: port i = [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    // Writeback port
    logic                     wen;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;

    // Issue port: destination register of an issued instruction becomes busy
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;

    // Full scoreboard state
    logic [DEPTH-1:0]         busy_vec;

    // Pipeline side: drives addresses, writes and issues, observes data and busy state
    modport master (
        output rd_addr, wen, waddr, wdata, issue_en, issue_addr,
        input  rd_data, rd_busy, busy_vec
    );

    // Register file side
    modport slave (
        input  rd_addr, wen, waddr, wdata, issue_en, issue_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised multi-read-port register file with a per-register busy scoreboard.
// Synchronous write, async active-low clear, optional hardwired-zero register 0,
// optional same-cycle write->read bypass and optional registered read outputs.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_file_param_if.slave    bus
);

    // An address is "live" when it names a real register that can hold state:
    // below DEPTH (non-power-of-2 depths leave holes) and not the hardwired zero.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range  = (int'(a) < DEPTH);
        is_zero   = (ZERO_REG != 0) && (a == '0);
        addr_live = in_range && !is_zero;
    endfunction

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [ADDR_W-1:0]        addr_arr [NUM_RD];
    logic                     write_ok;
    logic                     issue_ok;
    logic [NUM_RD*DATA_W-1:0] comb_data;
    logic [NUM_RD-1:0]        comb_busy;

    // Writes and issues to dead addresses (out of range or register 0) have no effect.
    assign write_ok = bus.wen      && addr_live(bus.waddr);
    assign issue_ok = bus.issue_en && addr_live(bus.issue_addr);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_addr
        assign addr_arr[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end

    // Register storage: written at the clock edge, cleared asynchronously.
    // NOTE: the storage array is reset entry by entry because the architecture
    // requires every register to read 0 after reset; this keeps it in flops.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (write_ok && (bus.waddr == ADDR_W'(r))) begin
                    regs[r] <= bus.wdata;
                end
            end
        end
    end

    // Scoreboard: issue sets busy, writeback clears it; issue wins because the
    // newly issued producer is still outstanding after this write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if ((ZERO_REG != 0) && (r == 0)) begin
                    busy[r] <= 1'b0;
                end else if (issue_ok && (bus.issue_addr == ADDR_W'(r))) begin
                    busy[r] <= 1'b1;
                end else if (write_ok && (bus.waddr == ADDR_W'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign bus.busy_vec = busy;

    // Combinational read value per port, including the optional bypass of the
    // write in flight; a bypassed read also sees its producer as retired.
    // NOTE: outputs get a default at the top so no path through the loop
    // leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        comb_data = '0;
        comb_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_live(addr_arr[i])) begin
                if ((BYPASS != 0) && write_ok && (bus.waddr == addr_arr[i])) begin
                    comb_data[i*DATA_W +: DATA_W] = bus.wdata;
                end else begin
                    comb_data[i*DATA_W +: DATA_W] = regs[addr_arr[i]];
                    comb_busy[i]                  = busy[addr_arr[i]];
                end
            end
        end
    end

    if (READ_LAT != 0) begin : g_rd_reg
        logic [NUM_RD*DATA_W-1:0] rd_data_q;
        logic [NUM_RD-1:0]        rd_busy_q;

        // Registered read: one cycle of latency for both data and busy.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
                rd_busy_q <= '0;
            end else begin
                rd_data_q <= comb_data;
                rd_busy_q <= comb_busy;
            end
        end

        assign bus.rd_data = rd_data_q;
        assign bus.rd_busy = rd_busy_q;
    end else begin : g_rd_comb
        assign bus.rd_data = comb_data;
        assign bus.rd_busy = comb_busy;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three configurations share clk/rst_n.
//   u_a: default (bypass, combinational read, 32 regs, 2 ports)
//   u_b: bypass disabled
//   u_c: registered read, 3 ports, 24 regs
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    reg_file_param_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus_a ();
    reg_file_param_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus_b ();
    reg_file_param_if #(.DATA_W(32), .DEPTH(24), .NUM_RD(3)) bus_c ();

    reg_file_param #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    reg_file_param #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .READ_LAT(0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    reg_file_param #(.DATA_W(32), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1), .READ_LAT(1))
        u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // One cycle of stimulus for u_a with its expected same-cycle reads and post-edge scoreboard
    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rb;
        logic [31:0] bv;
    } vec_t;

    // Expected registered outputs of u_c
    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  rb;
    } cexp_t;

    localparam int NVEC = 14;
    vec_t  vecs [NVEC];
    vec_t  sb_a [$];
    cexp_t sb_c [$];
    cexp_t last_c;

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] rb, input logic [31:0] bv);
        vec_t v;
        v.wen = w;  v.waddr = wa; v.wdata = wd; v.ie = ie; v.ia = ia;
        v.ra0 = r0; v.ra1 = r1;   v.d0 = d0;    v.d1 = d1; v.rb = rb; v.bv = bv;
        return v;
    endfunction

    function automatic cexp_t mkc(input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [2:0] rb);
        cexp_t e;
        e.d0 = d0; e.d1 = d1; e.d2 = d2; e.rb = rb;
        return e;
    endfunction

    task automatic idle_all();
        bus_a.wen = 0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.issue_en = 0; bus_a.issue_addr = '0; bus_a.rd_addr = '0;
        bus_b.wen = 0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.issue_en = 0; bus_b.issue_addr = '0; bus_b.rd_addr = '0;
        bus_c.wen = 0; bus_c.waddr = '0; bus_c.wdata = '0; bus_c.issue_en = 0; bus_c.issue_addr = '0; bus_c.rd_addr = '0;
    endtask

    task automatic drive_a(input vec_t v);
        bus_a.wen        = v.wen;
        bus_a.waddr      = v.waddr;
        bus_a.wdata      = v.wdata;
        bus_a.issue_en   = v.ie;
        bus_a.issue_addr = v.ia;
        bus_a.rd_addr    = {v.ra1, v.ra0};
    endtask

    // One u_c cycle: drive, push expectation, confirm outputs still hold the
    // previous registered value before the edge, then pop and compare after it.
    task automatic c_step(input string tag, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ie, input logic [4:0] ia,
                          input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                          input cexp_t e);
        cexp_t got;
        bus_c.wen = w; bus_c.waddr = wa; bus_c.wdata = wd;
        bus_c.issue_en = ie; bus_c.issue_addr = ia;
        bus_c.rd_addr = {r2, r1, r0};
        sb_c.push_back(e);
        @(negedge clk);
        check({tag, " hold d1"}, bus_c.rd_data[63:32], last_c.d1);
        @(posedge clk);
        #1;
        got = sb_c.pop_front();
        check({tag, " d0"}, bus_c.rd_data[31:0],  got.d0);
        check({tag, " d1"}, bus_c.rd_data[63:32], got.d1);
        check({tag, " d2"}, bus_c.rd_data[95:64], got.d2);
        check({tag, " rb"}, bus_c.rd_busy,        got.rb);
        last_c = got;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;

        //                wen wa  wdata          ie ia  ra0 ra1 d0             d1             rb     bv
        vecs[0]  = mk(1, 5,  32'hDEAD_BEEF, 0, 0,  5,  6,  32'hDEAD_BEEF, 32'h0,         2'b00, 32'h0);
        vecs[1]  = mk(0, 0,  32'h0,         0, 0,  5,  0,  32'hDEAD_BEEF, 32'h0,         2'b00, 32'h0);
        vecs[2]  = mk(1, 0,  32'hFFFF_FFFF, 1, 0,  0,  5,  32'h0,         32'hDEAD_BEEF, 2'b00, 32'h0);
        vecs[3]  = mk(0, 0,  32'h0,         1, 7,  7,  0,  32'h0,         32'h0,         2'b00, 32'h0000_0080);
        vecs[4]  = mk(0, 0,  32'h0,         0, 0,  7,  7,  32'h0,         32'h0,         2'b11, 32'h0000_0080);
        vecs[5]  = mk(1, 7,  32'h12,        0, 0,  7,  5,  32'h12,        32'hDEAD_BEEF, 2'b00, 32'h0);
        vecs[6]  = mk(0, 0,  32'h0,         1, 9,  7,  9,  32'h12,        32'h0,         2'b00, 32'h0000_0200);
        vecs[7]  = mk(1, 9,  32'hA5A5_0009, 1, 9,  9,  9,  32'hA5A5_0009, 32'hA5A5_0009, 2'b00, 32'h0000_0200);
        vecs[8]  = mk(0, 0,  32'h0,         0, 0,  9,  3,  32'hA5A5_0009, 32'h0,         2'b01, 32'h0000_0200);
        vecs[9]  = mk(1, 9,  32'h99,        1, 3,  9,  3,  32'h99,        32'h0,         2'b00, 32'h0000_0008);
        vecs[10] = mk(1, 3,  32'h33,        0, 0,  3,  9,  32'h33,        32'h99,        2'b00, 32'h0);
        vecs[11] = mk(1, 31, 32'hFFFF_0000, 0, 0,  31, 31, 32'hFFFF_0000, 32'hFFFF_0000, 2'b00, 32'h0);
        vecs[12] = mk(0, 0,  32'h0,         1, 31, 31, 1,  32'hFFFF_0000, 32'h0,         2'b00, 32'h8000_0000);
        vecs[13] = mk(0, 0,  32'h0,         0, 0,  31, 31, 32'hFFFF_0000, 32'hFFFF_0000, 2'b11, 32'h8000_0000);

        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        bus_a.rd_addr = {5'd31, 5'd5};
        #1;
        check("rst a rd_data", bus_a.rd_data, 64'h0);
        check("rst a busy_vec", bus_a.busy_vec, 32'h0);
        check("rst b busy_vec", bus_b.busy_vec, 32'h0);
        check("rst c busy_vec", bus_c.busy_vec, 24'h0);
        check("rst c rd_data", bus_c.rd_data[63:0], 64'h0);
        check("rst c rd_busy", bus_c.rd_busy, 3'b000);

        // Table-driven main sequence on u_a
        @(posedge clk);
        #1;
        for (int k = 0; k < NVEC; k++) begin
            drive_a(vecs[k]);
            sb_a.push_back(vecs[k]);
            @(negedge clk);
            e = sb_a.pop_front();
            check($sformatf("a%0d d0", k), bus_a.rd_data[31:0],  e.d0);
            check($sformatf("a%0d d1", k), bus_a.rd_data[63:32], e.d1);
            check($sformatf("a%0d rb", k), bus_a.rd_busy,        e.rb);
            @(posedge clk);
            #1;
            check($sformatf("a%0d bv", k), bus_a.busy_vec, e.bv);
        end

        // Async reset mid-run with a write held: no clock edge needed, write discarded
        bus_a.issue_en = 0;
        bus_a.wen = 1; bus_a.waddr = 5'd4; bus_a.wdata = 32'h4444;
        bus_a.rd_addr = {5'd9, 5'd31};
        #1 rst_n = 1'b0;
        #1;
        check("mid rst d0", bus_a.rd_data[31:0],  32'h0);
        check("mid rst d1", bus_a.rd_data[63:32], 32'h0);
        check("mid rst bv", bus_a.busy_vec, 32'h0);
        @(posedge clk);
        #1;
        bus_a.waddr = 5'd6; bus_a.wdata = 32'h6666;
        bus_a.rd_addr = {5'd4, 5'd31};
        #1;
        check("rst write discarded", bus_a.rd_data[63:32], 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_a.wen = 0;
        bus_a.rd_addr = {5'd4, 5'd6};
        #1;
        check("first write after rst", bus_a.rd_data[31:0],  32'h6666);
        check("reg4 after rst",        bus_a.rd_data[63:32], 32'h0);

        // u_b: no bypass -> old value during the write cycle, new value after the edge
        @(posedge clk);
        #1;
        bus_b.wen = 1; bus_b.waddr = 5'd5; bus_b.wdata = 32'hDEAD_BEEF;
        bus_b.rd_addr = {5'd5, 5'd5};
        @(negedge clk);
        check("b nobypass old", bus_b.rd_data[31:0], 32'h0);
        @(posedge clk);
        #1;
        bus_b.wen = 0;
        check("b after edge", bus_b.rd_data[31:0], 32'hDEAD_BEEF);
        bus_b.issue_en = 1; bus_b.issue_addr = 5'd7;
        bus_b.rd_addr = {5'd7, 5'd7};
        @(posedge clk);
        #1;
        bus_b.issue_en = 0;
        bus_b.wen = 1; bus_b.waddr = 5'd7; bus_b.wdata = 32'h12;
        @(negedge clk);
        check("b busy in write cycle", bus_b.rd_busy, 2'b11);
        check("b data in write cycle", bus_b.rd_data[31:0], 32'h0);
        @(posedge clk);
        #1;
        bus_b.wen = 0;
        check("b busy after write", bus_b.rd_busy, 2'b00);
        check("b data after write", bus_b.rd_data[31:0], 32'h12);
        check("b bv after write", bus_b.busy_vec, 32'h0);

        // u_c: registered reads, 3 ports, DEPTH=24 (addr 30 is a hole)
        last_c = mkc(32'h0, 32'h0, 32'h0, 3'b000);
        c_step("c0", 1, 5'd3,  32'h55,  0, 5'd0,  5'd3, 5'd3,  5'd3,  mkc(32'h55, 32'h55, 32'h55, 3'b000));
        c_step("c1", 0, 5'd0,  32'h0,   0, 5'd0,  5'd3, 5'd3,  5'd3,  mkc(32'h55, 32'h55, 32'h55, 3'b000));
        c_step("c2", 0, 5'd0,  32'h0,   1, 5'd3,  5'd3, 5'd30, 5'd0,  mkc(32'h55, 32'h0,  32'h0,  3'b000));
        c_step("c3", 1, 5'd30, 32'hBAD, 1, 5'd30, 5'd3, 5'd30, 5'd30, mkc(32'h55, 32'h0,  32'h0,  3'b001));
        check("c bv after c3", bus_c.busy_vec, 24'h000008);
        c_step("c4", 1, 5'd3,  32'h77,  0, 5'd0,  5'd3, 5'd3,  5'd20, mkc(32'h77, 32'h77, 32'h0,  3'b000));
        check("c bv after c4", bus_c.busy_vec, 24'h000000);
        c_step("c5", 0, 5'd0,  32'h0,   0, 5'd0,  5'd3, 5'd30, 5'd3,  mkc(32'h77, 32'h0,  32'h77, 3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
